// File: rtl/alu_muldiv_pkg.sv
// Shared execute-stage datatypes: integer ALU and RV32M mul/div op codes.
package alu_muldiv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // funct3 order, so bit 2 marks divide and bit 1 marks remainder
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result handshake bundle between the execute stage and the mul/div unit.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    import alu_muldiv_pkg::*;

    logic             in_valid;
    logic             in_ready;
    md_op_t           in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_y
    );

endinterface

// File: rtl/alu_muldiv_md_step.sv
// One iteration of the mul/div datapath: shift-add multiply or restoring divide.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;
    logic [WIDTH:0] diff;

    // acc = {hi, lo}: product/multiplier or remainder/dividend-quotient
    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = shl - {1'b0, opnd};
        nxt  = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (diff[WIDTH]) begin
                nxt = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit, one result bit per cycle on magnitudes,
// with sign fix-up on the final edge and single-cycle special cases.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_nxt;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   y_q;
    md_op_t             op;
    logic               negq;
    logic               negr;
    logic               rdy;
    logic               vld;

    logic [WIDTH-1:0] a, b, ma, mb, spec_y;
    logic             sa, sb, in_div, div0, ovf, nq_in, nr_in;

    always_comb begin
        a      = bus.in_a;
        b      = bus.in_b;
        in_div = bus.in_op[2];
        sa     = 1'b0;
        sb     = 1'b0;
        unique case (1'b1)
            bus.in_op == MD_MULH:   begin sa = 1'b1; sb = 1'b1; end
            bus.in_op == MD_MULHSU: sa = 1'b1;
            bus.in_op == MD_DIV,
            bus.in_op == MD_REM:    begin sa = 1'b1; sb = 1'b1; end
            default: ;
        endcase
        ma     = (sa && a[WIDTH-1]) ? -a : a;
        mb     = (sb && b[WIDTH-1]) ? -b : b;
        nq_in  = (sa & a[WIDTH-1]) ^ (sb & b[WIDTH-1]);
        nr_in  = sa & a[WIDTH-1];
        div0   = in_div && (b == '0);
        ovf    = in_div && sa && (a == MIN) && (b == '1);
        if (div0) begin
            spec_y = bus.in_op[1] ? a : '1;
        end else begin
            spec_y = bus.in_op[1] ? '0 : MIN;
        end
    end

    md_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op[2]),
        .acc    (acc),
        .opnd   (opnd),
        .nxt    (step_nxt)
    );

    logic [2*WIDTH-1:0] pneg;
    logic [WIDTH-1:0]   q, r, fin_y;
    logic               is_mul, is_mulh, is_quot, is_rem;

    // result select and sign fix-up applied to the last iteration's output
    always_comb begin
        pneg    = -step_nxt;
        q       = step_nxt[WIDTH-1:0];
        r       = step_nxt[2*WIDTH-1:WIDTH];
        is_mul  = (op == MD_MUL);
        is_mulh = !op[2] && !is_mul;
        is_quot = op[2] && !op[1];
        is_rem  = op[2] && op[1];
        fin_y   = '0;
        unique case (1'b1)
            is_mul:  fin_y = q;
            is_mulh: fin_y = negq ? pneg[2*WIDTH-1:WIDTH] : r;
            is_quot: fin_y = negq ? -q : q;
            is_rem:  fin_y = negr ? -r : r;
            default: fin_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            opnd  <= '0;
            op    <= MD_MUL;
            negq  <= 1'b0;
            negr  <= 1'b0;
            y_q   <= '0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op   <= bus.in_op;
                        negq <= nq_in;
                        negr <= nr_in;
                        rdy  <= 1'b0;
                        if (div0 || ovf) begin
                            y_q   <= spec_y;
                            state <= DONE;
                            vld   <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_W'(WIDTH);
                            acc   <= {{WIDTH{1'b0}}, in_div ? ma : mb};
                            opnd  <= in_div ? mb : ma;
                        end
                    end
                end
                BUSY: begin
                    acc <= step_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        y_q   <= fin_y;
                        state <= DONE;
                        vld   <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                        rdy   <= 1'b1;
                        vld   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    vld   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_y     = y_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed and random checks of alu_muldiv against a behavioural RV32M model.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q[$];

    typedef struct {
        md_op_t       op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
    } vec_t;

    vec_t tbl[14] = '{
        '{MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{MD_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
        '{MD_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
        '{MD_DIVU,   32'd100,       32'd7,         32'd14},
        '{MD_REMU,   32'd100,       32'd7,         32'd2},
        '{MD_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD},
        '{MD_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001},
        '{MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF},
        '{MD_REMU,   32'd5,         32'd0,         32'd5},
        '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
        '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
    };

    function automatic logic [W-1:0] model(md_op_t op, logic [W-1:0] a, logic [W-1:0] b);
        longint     sa, sb, ub;
        logic [63:0] ps, psu, pu, t;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ps  = sa * sb;
        psu = sa * ub;
        pu  = {32'd0, a} * {32'd0, b};
        case (op)
            MD_MUL:    return ps[31:0];
            MD_MULH:   return ps[63:32];
            MD_MULHSU: return psu[63:32];
            MD_MULHU:  return pu[63:32];
            MD_DIV: begin
                if (b == 0) return '1;
                t = sa / sb;
                return t[31:0];
            end
            MD_REM: begin
                if (b == 0) return a;
                t = sa % sb;
                return t[31:0];
            end
            MD_DIVU:   return (b == 0) ? '1 : a / b;
            MD_REMU:   return (b == 0) ? a : a % b;
            default:   return '0;
        endcase
    endfunction

    function automatic bit special(md_op_t op, logic [W-1:0] a, logic [W-1:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == '1));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(string tag, md_op_t op, logic [W-1:0] a, logic [W-1:0] b,
                       logic [W-1:0] exp);
        int lat;
        int want;
        want = special(op, a, b) ? 1 : W + 1;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        sb_q.push_back(exp);
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 3 * W) begin
            tick();
            lat++;
        end
        chk({tag, "/lat"}, 32'(lat), 32'(want));
        if (bus.out_valid) begin
            chk(tag, bus.out_y, sb_q.pop_front());
        end else begin
            void'(sb_q.pop_front());
        end
        tick();
    endtask

    initial begin
        md_op_t       rop;
        logic [W-1:0] ra, rb;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = MD_MUL;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst/in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst/out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst/out_y", bus.out_y, 32'd0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y);
        end

        for (int i = 0; i < 8; i++) begin
            rop = md_op_t'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? W'($urandom_range(0, 3)) : $urandom;
            run($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
        end

        bus.out_ready = 1'b0;
        run("hold", MD_DIVU, 32'd100, 32'd7, 32'd14);
        for (int i = 0; i < 10; i++) begin
            chk("hold/out_y", bus.out_y, 32'd14);
            chk("hold/in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("release/in_ready", 32'(bus.in_ready), 32'd1);
        chk("release/out_valid", 32'(bus.out_valid), 32'd0);

        bus.in_valid = 1'b1;
        bus.in_op    = MD_MUL;
        bus.in_a     = 32'd5;
        bus.in_b     = 32'd6;
        flush        = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        chk("flushreq/in_ready", 32'(bus.in_ready), 32'd1);

        bus.in_valid = 1'b1;
        bus.in_a     = 32'd9;
        bus.in_b     = 32'd9;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        chk("busy/in_ready", 32'(bus.in_ready), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush/out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush/in_ready", 32'(bus.in_ready), 32'd1);
        run("after_flush", MD_MUL, 32'd3, 32'd4, 32'd12);

        bus.in_valid = 1'b1;
        bus.in_op    = MD_DIVU;
        bus.in_a     = 32'd1000;
        bus.in_b     = 32'd3;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst/out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst/out_y", bus.out_y, 32'd0);
        chk("midrst/in_ready", 32'(bus.in_ready), 32'd1);
        run("after_rst", MD_MUL, 32'd3, 32'd4, 32'd12);

        bus.out_ready = 1'b0;
        run("done_flush", MD_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        chk("doneflush/out_valid", 32'(bus.out_valid), 32'd0);
        chk("doneflush/in_ready", 32'(bus.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
